// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/mem/wb, Moore outputs gated low during reset.
// Memory states are held MEM_LAT cycles via a latency counter; optional addi path behind `ADDI_SUPPORT_EN.
module mips_multicycle_control #(
    parameter int OP_W    = 6,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] Op,
    output logic            PCWrite,
    output logic            Branch,
    output logic [1:0]      PCSrc,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            MemtoReg,
    output logic            RegDst,
    output logic            RegWrite,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ALUOp,
    output logic [3:0]      state,
    output logic            illegal_op,
    output logic            instr_done
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [OP_W-1:0]  OP_RTYPE = OP_W'('h00);
    localparam logic [OP_W-1:0]  OP_J     = OP_W'('h02);
    localparam logic [OP_W-1:0]  OP_BEQ   = OP_W'('h04);
    localparam logic [OP_W-1:0]  OP_LW    = OP_W'('h23);
    localparam logic [OP_W-1:0]  OP_SW    = OP_W'('h2B);
`ifdef ADDI_SUPPORT_EN
    localparam logic [OP_W-1:0]  OP_ADDI  = OP_W'('h08);
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              last;
    logic              in_access;
    state_t            dec_next;
    logic              dec_legal;

    assign last      = (cnt_q == LAST_CNT);
    assign in_access = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

    // Opcode decode is only consumed in DECODE; op_q carries it forward so later Op changes are ignored.
    always_comb begin
        dec_next  = S_FETCH;
        dec_legal = 1'b1;
        if (Op == OP_LW || Op == OP_SW) begin
            dec_next = S_MEMADR;
        end else if (Op == OP_RTYPE) begin
            dec_next = S_EXECUTE;
        end else if (Op == OP_BEQ) begin
            dec_next = S_BRANCH;
        end else if (Op == OP_J) begin
            dec_next = S_JUMP;
`ifdef ADDI_SUPPORT_EN
        end else if (Op == OP_ADDI) begin
            dec_next = S_ADDIEX;
`endif
        end else begin
            dec_legal = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = (in_access && !last) ? cnt_q + CNT_W'(1) : '0;
        case (state_q)
            S_FETCH:   if (last) state_d = S_DECODE;
            S_DECODE: begin
                op_d    = Op;
                state_d = dec_next;
            end
            S_MEMADR: begin
                if (op_q == OP_LW)      state_d = S_MEMRD;
                else if (op_q == OP_SW) state_d = S_MEMWR;
                else                    state_d = S_FETCH;
            end
            S_MEMRD:   if (last) state_d = S_MEMWB;
            S_MEMWR:   if (last) state_d = S_FETCH;
            S_MEMWB:   state_d = S_FETCH;
            S_EXECUTE: state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
`ifdef ADDI_SUPPORT_EN
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
`endif
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    assign state = reset ? 4'd0 : state_q;

    // Reset forces every strobe low even while state_q still holds a mid-instruction code.
    always_comb begin
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        PCSrc      = 2'b00;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        illegal_op = 1'b0;
        instr_done = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = last;
                    PCWrite = last;
                end
                S_DECODE: begin
                    ALUSrcB    = 2'b11;
                    illegal_op = !dec_legal;
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                end
                S_MEMWB: begin
                    MemtoReg   = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    IorD       = 1'b1;
                    MemWrite   = 1'b1;
                    instr_done = last;
                end
                S_EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_ALUWB: begin
                    RegDst     = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA    = 1'b1;
                    ALUOp      = 2'b01;
                    Branch     = 1'b1;
                    PCSrc      = 2'b01;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    PCSrc      = 2'b10;
                    PCWrite    = 1'b1;
                    instr_done = 1'b1;
                end
`ifdef ADDI_SUPPORT_EN
                S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_ADDIWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multicycle successor to the single-cycle MIPS Control unit.
- Moore FSM that sequences FETCH/DECODE/EXECUTE/MEM/WB over several clocks, driven by the 6-bit opcode from the instruction register.
- Adds a parametrised memory-latency wait counter, an opcode latch, an illegal-opcode flag and an instruction-retire pulse.
- Sits between the IR and the shared datapath (PC, single memory, ALU, register file).

Parameters:
- OP_W, 6, opcode width; encodings below are zero-extended to OP_W.
- MEM_LAT, 1, cycles each memory access state is held (legal 1..15).
- CNT_W, 4, width of the latency counter; must satisfy 2^CNT_W > MEM_LAT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- Op  in  OP_W  opcode field from IR; sampled only in DECODE
- PCWrite  out  1  unconditional PC load
- Branch  out  1  conditional PC load (datapath ANDs it with Zero)
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR load enable
- MemtoReg  out  1  write-back select: 1 = MDR, 0 = ALUOut
- RegDst  out  1  destination register select: 1 = rd, 0 = rt
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = A register
- ALUSrcB  out  2  ALU B input: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = shifted imm
- ALUOp  out  2  00 = add, 01 = subtract, 10 = funct field
- state  out  4  current state code (debug)
- illegal_op  out  1  one-cycle pulse on an undecodable opcode
- instr_done  out  1  one-cycle pulse in the last cycle of every legal instruction

Behaviour:
- One clock domain. Reset is synchronous and active-high; ports are named clk and reset.
- While reset is high: every output is 0, state is set to FETCH, cnt = 0, op_q = 0. The first cycle after reset falls is FETCH with cnt = 0.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12-15 are unreachable; if entered, go to FETCH with all outputs 0.
- Outputs are decoded combinationally from state and cnt only (Moore). Any signal not listed for a state is 0.
- Latency counter:
  - cnt increments while in FETCH, MEMRD or MEMWR.
  - "last" means cnt == MEM_LAT-1; leaving the state clears cnt.
  - With MEM_LAT = 1 every access is a single cycle.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite=1 and PCWrite=1 only on the last cycle. Last cycle -> DECODE, otherwise stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Latch op_q <= Op. Next state from Op:
  - 0x23 or 0x2B -> MEMADR
  - 0x00 -> EXECUTE
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - 0x08 -> ADDIEX (only with the optional feature)
  - anything else -> FETCH, with illegal_op=1 in this DECODE cycle
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state uses op_q, not live Op: 0x23 -> MEMRD, 0x2B -> MEMWR.
- MEMRD: IorD=1, MemRead=1 for MEM_LAT cycles -> MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1 -> FETCH.
- MEMWR: IorD=1, MemWrite=1 for MEM_LAT cycles. instr_done=1 on the last cycle -> FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch=1, PCSrc=01, instr_done=1 -> FETCH.
- JUMP: PCSrc=10, PCWrite=1, instr_done=1 -> FETCH.
- Instruction cycle counts (M = MEM_LAT):
  - lw: 2M+3
  - sw: 2M+2
  - R-type: M+3
  - beq, j: M+2
  - illegal: M+1
- Changes on Op outside DECODE have no effect.
- Reset asserted mid-instruction aborts it: no RegWrite/MemWrite pulse follows, and the next instruction starts at FETCH.
- MemWrite and RegWrite are never high in the same cycle.

Optional Feature:
- Macro ADDI_SUPPORT_EN.
- Defined: opcode 0x08 goes DECODE -> ADDIEX -> ADDIWB -> FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1.
- Undefined: 0x08 is treated as illegal and ADDIEX/ADDIWB are unreachable (treated as codes 12-15).

Test Plan:
- MEM_LAT=1, Op=0x00 -> state sequence 0,1,6,7,0; RegWrite=1 and RegDst=1 only in cycle 4; instr_done pulses once.
- MEM_LAT=3, Op=0x23 -> FETCH held 3 cycles with IRWrite/PCWrite only in the 3rd; MEMRD held 3 cycles; 9 cycles total; MemtoReg=1 in MEMWB.
- Op=0x2B, Op changed to 0x23 during MEMADR -> still enters MEMWR; MemWrite=1 for MEM_LAT cycles; RegWrite stays 0 throughout.
- Op=0x04, then Op=0x02 -> BRANCH shows Branch=1, PCSrc=01, ALUOp=01; JUMP shows PCWrite=1, PCSrc=10.
- Op=0x11 -> illegal_op=1 for exactly one cycle in DECODE, back to FETCH, instr_done stays 0. Op=0x08 behaves the same without ADDI_SUPPORT_EN; with it, state goes 9 then 10 with RegWrite=1 and RegDst=0.
- reset=1 for one cycle during MEMRD (MEM_LAT=3) -> all outputs 0 that cycle, then FETCH with cnt=0; no MEMWB occurs.
